// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and
// the counter width helper.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Iteration counter width; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addern.sv
// n-bit adder with carry-in and carry-out.
module addern #(
  parameter int unsigned n = 8
) (
  input  logic         carryin,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic [n-1:0] s,
  output logic         c
);

  assign {c, s} = {1'b0, x} + {1'b0, y} + {{n{1'b0}}, carryin};

endmodule

// File: rtl/multi_and.sv
// Partial-product row: every bit of a ANDed with the single bit b.
module multi_and #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0] a,
  input  logic         b,
  output logic [n-1:0] y
);

  assign y = a & {n{b}};

endmodule

// File: rtl/seq_mult_shift_add_step.sv
// One shift-add iteration: add M to A when Q[0] is set, then shift {c, s, Q}
// right by one.
module shift_add_step #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  output logic [N-1:0] a_next,
  output logic [N-1:0] q_next
);

  logic [N-1:0] pp;
  logic [N-1:0] sum;
  logic         cout;

  multi_and #(
    .n (N)
  ) u_row (
    .a (m),
    .b (q[0]),
    .y (pp)
  );

  addern #(
    .n (N)
  ) u_add (
    .carryin (1'b0),
    .x       (a),
    .y       (pp),
    .s       (sum),
    .c       (cout)
  );

  // The carry-out becomes A's new MSB, so the product never overflows.
  assign {a_next, q_next} = {cout, sum, q[N-1:1]};

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier controller: N iterations of one shared
// AND-row and adder produce a 2N-bit product with a start/done handshake.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  state_e        state;
  logic [N-1:0]  a_q, q_q, m_q;
  logic [N-1:0]  a_next, q_next;
  logic [CntW-1:0] cnt;

  shift_add_step #(
    .N (N)
  ) u_step (
    .a      (a_q),
    .q      (q_q),
    .m      (m_q),
    .a_next (a_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          // DONE accepts start too, giving back-to-back operation.
          if (start) begin
            m_q   <= X;
            q_q   <= Y;
            a_q   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q <= a_next;
          q_q <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == CntLast) begin
            P     <= {a_next, q_next};
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and randomized checks of seq_mult_ctrl at N=8 plus an N=2 instance.
module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  X, Y;
  logic        busy, done;
  logic [15:0] P;

  logic        start2;
  logic [1:0]  x2, y2;
  logic        busy2, done2;
  logic [3:0]  p2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mult_ctrl #(
    .N (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .X     (X),
    .Y     (Y),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  seq_mult_ctrl #(
    .N (2)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .X     (x2),
    .Y     (y2),
    .busy  (busy2),
    .done  (done2),
    .P     (p2)
  );

  // Issues one multiply on the N=8 instance; lat is the cycle count after
  // acceptance at which done is seen (-1 on timeout).
  task automatic run_op8(input logic [7:0] xv, input logic [7:0] yv,
                         output logic [15:0] pv, output int lat, output int bcnt);
    @(negedge clk);
    X = xv; Y = yv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; bcnt = 0; pv = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i; pv = P;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; X = 8'd9; Y = 8'd9;
    start2 = 1'b1; x2 = 2'd1; y2 = 2'd1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || P !== 16'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b P=%0d want 0 0 0", busy, done, P);
    end
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || p2 !== 4'd0) begin
      errors++;
      $display("FAIL reset2: busy=%b done=%b P=%0d want 0 0 0", busy2, done2, p2);
    end
    reset = 1'b0; start = 1'b0; start2 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [15:0] pv; int lat, bcnt;
    run_op8(8'd13, 8'd11, pv, lat, bcnt);
    checks++;
    if (pv !== 16'd143) begin errors++; $display("FAIL basic_p: got %0d want 143", pv); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_lat: got %0d want 9", lat); end
    checks++;
    if (bcnt !== 8) begin errors++; $display("FAIL basic_busy: got %0d want 8", bcnt); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || P !== 16'd143) begin
      errors++;
      $display("FAIL basic_hold: done=%b busy=%b P=%0d want 0 0 143", done, busy, P);
    end
  endtask

  task automatic test_max();
    logic [15:0] pv; int lat, bcnt;
    run_op8(8'd255, 8'd255, pv, lat, bcnt);
    checks++;
    if (pv !== 16'hFE01) begin errors++; $display("FAIL max_p: got %h want fe01", pv); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL max_lat: got %0d want 9", lat); end
  endtask

  task automatic test_zero();
    logic [15:0] pv; int lat, bcnt;
    run_op8(8'd0, 8'd200, pv, lat, bcnt);
    checks++;
    if (pv !== 16'd0) begin errors++; $display("FAIL zero_x_p: got %0d want 0", pv); end
    checks++;
    if (lat !== 9 || bcnt !== 8) begin
      errors++;
      $display("FAIL zero_x_lat: lat=%0d busy=%0d want 9 8", lat, bcnt);
    end
    run_op8(8'd200, 8'd0, pv, lat, bcnt);
    checks++;
    if (pv !== 16'd0) begin errors++; $display("FAIL zero_y_p: got %0d want 0", pv); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL zero_y_lat: got %0d want 9", lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] p1;
    @(negedge clk);
    X = 8'd10; Y = 8'd20; start = 1'b1;
    @(posedge clk);
    lat = -1; p1 = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; p1 = P;
        X = 8'd7; Y = 8'd6;
        break;
      end
      X = 8'(i + 50); Y = 8'(i + 90);
    end
    checks++;
    if (p1 !== 16'd200 || lat !== 9) begin
      errors++;
      $display("FAIL ignore_p: P=%0d lat=%0d want 200 9", p1, lat);
    end
    @(posedge clk);
    #1 start = 1'b0; X = 8'd99; Y = 8'd99;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    lat = -1; p1 = 'x;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; p1 = P;
        break;
      end
    end
    checks++;
    if (p1 !== 16'd42 || lat !== 9) begin
      errors++;
      $display("FAIL b2b_p: P=%0d lat=%0d want 42 9", p1, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] pv; int lat, bcnt; int seen;
    @(negedge clk);
    X = 8'd100; Y = 8'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || P !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b P=%0d want 0 0 0", busy, done, P);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL no_done_after_reset: got %0d want 0", seen); end
    run_op8(8'd3, 8'd5, pv, lat, bcnt);
    checks++;
    if (pv !== 16'd15 || lat !== 9) begin
      errors++;
      $display("FAIL post_reset_p: P=%0d lat=%0d want 15 9", pv, lat);
    end
  endtask

  task automatic test_n2();
    logic [1:0] xs [2] = '{2'd3, 2'd2};
    logic [1:0] ys [2] = '{2'd3, 2'd3};
    logic [3:0] want [2] = '{4'd9, 4'd6};
    int lat, bcnt; logic [3:0] pv;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      x2 = xs[k]; y2 = ys[k]; start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      lat = -1; bcnt = 0; pv = 'x;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (busy2) bcnt++;
        if (done2) begin
          lat = i; pv = p2;
          break;
        end
      end
      checks++;
      if (pv !== want[k] || lat !== 3 || bcnt !== 2) begin
        errors++;
        $display("FAIL n2_op%0d: P=%0d lat=%0d busy=%0d want %0d 3 2", k, pv, lat, bcnt, want[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] pv, exp; int lat, bcnt;
    logic [7:0] xv, yv;
    for (int k = 0; k < 1000; k++) begin
      xv = 8'($urandom); yv = 8'($urandom);
      exp = 16'(xv) * 16'(yv);
      run_op8(xv, yv, pv, lat, bcnt);
      checks++;
      if (pv !== exp || lat !== 9) begin
        errors++;
        $display("FAIL rand_%0d: %0d*%0d P=%0d lat=%0d want %0d 9", k, xv, yv, pv, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_async_reset();
    test_n2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
